fsm_transition_monitor: RTL and testbench

- Parametrised run-time monitor for the benchmark FSMs.
- Samples a target FSM's state register and counts occurrences of up to NUM_CH programmable (from-state, to-state) transitions, each in its own channel.
- Flags channels whose count reaches a programmable threshold and latches a sticky alarm.
- Sits beside the FSM under test and is used to expose rarely exercised transitions such as counter-gated output paths; it is not instantiated in the FSM itself.

---
 rtl/fsm_mon_pkg.sv | 26 ++
 rtl/fsm_mon_channel.sv | 61 ++++++
 rtl/fsm_transition_monitor.sv | 153 +++++++++++++++
 tb/tb_fsm_transition_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_mon_pkg.sv
// fsm_mon_pkg
//   Shared definitions for the FSM transition monitor: mode encodings, the
//   per-channel configuration record and a saturating-increment helper.
//   MON_STATE_W / MON_CNT_W fix the widths of the configuration record and
//   must match the STATE_W / CNT_W parameters of fsm_transition_monitor.
package fsm_mon_pkg;

    localparam int unsigned MON_STATE_W = 4;
    localparam int unsigned MON_CNT_W   = 8;

    localparam logic MODE_CUMULATIVE = 1'b0;
    localparam logic MODE_WINDOWED   = 1'b1;

    typedef struct packed {
        logic                   en;
        logic [MON_STATE_W-1:0] from;
        logic [MON_STATE_W-1:0] to;
        logic [MON_CNT_W-1:0]   thresh;
    } ch_cfg_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MON_CNT_W-1:0] sat_inc(input logic [MON_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fsm_mon_channel.sv
// fsm_mon_channel
//   One transition channel: configuration registers, (from, to) match
//   compare, saturating occurrence counter and threshold compare.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         synchronous clear of the counter (configuration kept)
//   cfg_wr_i      write cfg_i into this channel and clear its counter
//   cfg_i         configuration record to write
//   win_clr_i     window expiry: counter returns to zero
//   sample_i      monitor enabled and previous state valid this cycle
//   prev_i/cur_i  previous and present state of the monitored FSM
//   cnt_o         occurrence count
//   hit_o         threshold reached (never with a zero threshold)
module fsm_mon_channel
    import fsm_mon_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   cfg_wr_i,
    input  ch_cfg_t                cfg_i,
    input  logic                   win_clr_i,
    input  logic                   sample_i,
    input  logic [MON_STATE_W-1:0] prev_i,
    input  logic [MON_STATE_W-1:0] cur_i,
    output logic [MON_CNT_W-1:0]   cnt_o,
    output logic                   hit_o
);

    ch_cfg_t              cfg_q;
    logic [MON_CNT_W-1:0] cnt_q, cnt_d;
    logic                 match;

    assign match = sample_i & cfg_q.en & (prev_i == cfg_q.from) & (cur_i == cfg_q.to);

    // Clear, reconfiguration and window expiry all discard a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || cfg_wr_i || win_clr_i) begin
            cnt_d = '0;
        end else if (match) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (cfg_wr_i && !clr_i) begin
                cfg_q <= cfg_i;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cfg_q.thresh != '0) && (cnt_q >= cfg_q.thresh);

endmodule

// File: rtl/fsm_transition_monitor.sv
// fsm_transition_monitor
//   Run-time monitor that watches a target FSM's state register and counts
//   up to NUM_CH programmable (from, to) transitions, one per channel.
//   Channels reaching their threshold raise hit_o; the first hit latches a
//   sticky alarm together with the lowest-indexed hitting channel.
//   In windowed mode all counters restart every window_len enabled cycles.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            sampling enable; nothing advances while low
//   state_i       present state of the monitored FSM
//   clr           synchronous clear of counters, alarm and window
//   cfg_*         configuration write port (one channel per cycle, plus the
//                 global mode and window length on every write)
//   cnt_o         packed per-channel counts, channel k at [k*CNT_W +: CNT_W]
//   hit_o         per-channel threshold reached
//   alarm_o       sticky alarm
//   alarm_ch_o    channel that raised the alarm
module fsm_transition_monitor
    import fsm_mon_pkg::*;
#(
    parameter int unsigned STATE_W = MON_STATE_W,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = MON_CNT_W,
    parameter int unsigned WIN_W   = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [STATE_W-1:0]      state_i,
    input  logic                    clr,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic                    cfg_en,
    input  logic [STATE_W-1:0]      cfg_from,
    input  logic [STATE_W-1:0]      cfg_to,
    input  logic [CNT_W-1:0]        cfg_thresh,
    input  logic                    cfg_mode,
    input  logic [WIN_W-1:0]        cfg_window,
    output logic [NUM_CH*CNT_W-1:0] cnt_o,
    output logic [NUM_CH-1:0]       hit_o,
    output logic                    alarm_o,
    output logic [CH_W-1:0]         alarm_ch_o
);

    // Previous-state tracking.
    logic [STATE_W-1:0] prev_q;
    logic               prev_valid_q;
    logic               sample;

    // Global configuration and observation window.
    logic               mode_q;
    logic [WIN_W-1:0]   win_len_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   win_last;
    logic               win_expire;

    // Alarm.
    logic               alarm_q;
    logic [CH_W-1:0]    alarm_ch_q;
    logic               hit_any;
    logic [CH_W-1:0]    first_hit;

    ch_cfg_t            wr_cfg;
    logic [NUM_CH-1:0]  ch_wr;

    assign sample = en & prev_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clr) begin
            prev_valid_q <= 1'b0;
        end else if (en) begin
            prev_q       <= state_i;
            prev_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_CUMULATIVE;
            win_len_q <= WIN_W'(1);
        end else if (cfg_we && !clr) begin
            mode_q    <= cfg_mode;
            win_len_q <= cfg_window;
        end
    end

    // A programmed length of 0 behaves as 1: the window expires every cycle.
    assign win_last   = (win_len_q == '0) ? '0 : win_len_q - WIN_W'(1);
    assign win_expire = en && (mode_q == MODE_WINDOWED) && (win_q == win_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (clr || cfg_we || (mode_q != MODE_WINDOWED)) begin
            win_q <= '0;
        end else if (en) begin
            win_q <= win_expire ? '0 : win_q + WIN_W'(1);
        end
    end

    assign wr_cfg = '{en: cfg_en, from: cfg_from, to: cfg_to, thresh: cfg_thresh};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Indices >= NUM_CH never equal k, so such writes touch only global fields.
        assign ch_wr[k] = cfg_we && (cfg_ch == CH_W'(k));

        fsm_mon_channel u_channel (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (clr),
            .cfg_wr_i  (ch_wr[k]),
            .cfg_i     (wr_cfg),
            .win_clr_i (win_expire),
            .sample_i  (sample),
            .prev_i    (prev_q),
            .cur_i     (state_i),
            .cnt_o     (cnt_o[k*CNT_W +: CNT_W]),
            .hit_o     (hit_o[k])
        );
    end

    // Lowest-indexed asserted hit wins.
    always_comb begin
        hit_any   = |hit_o;
        first_hit = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit_o[i]) begin
                first_hit = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q    <= 1'b0;
            alarm_ch_q <= '0;
        end else if (clr) begin
            alarm_q    <= 1'b0;
            alarm_ch_q <= '0;
        end else if (!alarm_q && hit_any) begin
            alarm_q    <= 1'b1;
            alarm_ch_q <= first_hit;
        end
    end

    assign alarm_o    = alarm_q;
    assign alarm_ch_o = alarm_ch_q;

endmodule

// File: tb/tb_fsm_transition_monitor.sv
module tb_fsm_transition_monitor;

    localparam int NCH = 4;
    localparam int SW  = 4;
    localparam int CW  = 8;
    localparam int WW  = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [SW-1:0]   state_i;
    logic            clr;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic            cfg_en;
    logic [SW-1:0]   cfg_from;
    logic [SW-1:0]   cfg_to;
    logic [CW-1:0]   cfg_thresh;
    logic            cfg_mode;
    logic [WW-1:0]   cfg_window;
    logic [NCH*CW-1:0] cnt_o;
    logic [NCH-1:0]  hit_o;
    logic            alarm_o;
    logic [1:0]      alarm_ch_o;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    int m_cnt[NCH];
    bit m_cen[NCH];
    int m_from[NCH];
    int m_to[NCH];
    int m_th[NCH];
    bit m_mode;
    int m_wlen;
    int m_win;
    int m_prev;
    bit m_pv;
    bit m_alarm;
    int m_alch;

    always #5 clk = ~clk;

    fsm_transition_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .state_i    (state_i),
        .clr        (clr),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_from   (cfg_from),
        .cfg_to     (cfg_to),
        .cfg_thresh (cfg_thresh),
        .cfg_mode   (cfg_mode),
        .cfg_window (cfg_window),
        .cnt_o      (cnt_o),
        .hit_o      (hit_o),
        .alarm_o    (alarm_o),
        .alarm_ch_o (alarm_ch_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int k);
        return (m_th[k] != 0) && (m_cnt[k] >= m_th[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = 0; m_cen[k] = 0; m_from[k] = 0; m_to[k] = 0; m_th[k] = 0;
        end
        m_mode = 0; m_wlen = 1; m_win = 0; m_prev = 0; m_pv = 0;
        m_alarm = 0; m_alch = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  wl;
        bit  expire;
        bit  any;
        int  low;
        bit  match;
        wl     = (m_wlen == 0) ? 1 : m_wlen;
        expire = en && m_mode && (m_win == wl - 1);
        any    = 0;
        low    = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m_hit(k)) begin any = 1; low = k; end
        end
        for (int k = 0; k < NCH; k++) begin
            match = en && m_pv && m_cen[k] && (m_prev == m_from[k]) &&
                    (int'(state_i) == m_to[k]);
            if (clr) m_cnt[k] = 0;
            else if (cfg_we && int'(cfg_ch) == k) m_cnt[k] = 0;
            else if (expire) m_cnt[k] = 0;
            else if (match && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
        end
        if (clr) begin
            m_alarm = 0; m_alch = 0;
        end else if (!m_alarm && any) begin
            m_alarm = 1; m_alch = low;
        end
        if (clr || cfg_we || !m_mode) m_win = 0;
        else if (en) m_win = expire ? 0 : m_win + 1;
        if (clr) m_pv = 0;
        else if (en) begin m_prev = int'(state_i); m_pv = 1; end
        if (cfg_we && !clr) begin
            if (int'(cfg_ch) < NCH) begin
                m_cen[cfg_ch]  = cfg_en;
                m_from[cfg_ch] = int'(cfg_from);
                m_to[cfg_ch]   = int'(cfg_to);
                m_th[cfg_ch]   = int'(cfg_thresh);
            end
            m_mode = cfg_mode;
            m_wlen = int'(cfg_window);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] eh;
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s cnt%0d", tag, k), 32'(cnt_o[k*CW +: CW]), m_cnt[k]);
            eh[k] = m_hit(k);
        end
        check({tag, " hit"}, 32'(hit_o), 32'(eh));
        check({tag, " alarm"}, 32'(alarm_o), 32'(m_alarm));
        check({tag, " alarm_ch"}, 32'(alarm_ch_o), m_alch);
    endtask

    task automatic drive(input string tag, input bit e, input int st, input bit c,
                         input bit we, input int ch, input bit ce, input int f, input int t,
                         input int th, input bit md, input int win);
        en = e; state_i = SW'(st); clr = c; cfg_we = we; cfg_ch = 2'(ch);
        cfg_en = ce; cfg_from = SW'(f); cfg_to = SW'(t); cfg_thresh = CW'(th);
        cfg_mode = md; cfg_window = WW'(win);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic cyc(input string tag, input bit e, input int st);
        drive(tag, e, st, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfgw(input int ch, input bit ce, input int f, input int t, input int th,
                        input bit md, input int win);
        drive("cfg", 0, 0, 0, 1, ch, ce, f, t, th, md, win);
    endtask

    task automatic clrc();
        drive("clr", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int seq3[8] = '{1, 2, 1, 2, 0, 0, 1, 2};

    initial begin
        en = 0; state_i = 0; clr = 0; cfg_we = 0; cfg_ch = 0; cfg_en = 0; cfg_from = 0;
        cfg_to = 0; cfg_thresh = 0; cfg_mode = 0; cfg_window = 0;
        rst = 1;
        model_reset();
        #2;
        check_all("reset");
        rst = 0;

        // Cumulative counting of 6->1.
        cfgw(0, 1, 6, 1, 3, 0, 0);
        cyc("t1 s6a", 1, 6);
        cyc("t1 s1a", 1, 1);
        check("t1 cnt=1", 32'(cnt_o[7:0]), 1);
        cyc("t1 s6b", 1, 6);
        cyc("t1 s1b", 1, 1);
        check("t1 cnt=2", 32'(cnt_o[7:0]), 2);
        cyc("t1 s6c", 1, 6);
        cyc("t1 s1c", 1, 1);
        check("t1 cnt=3", 32'(cnt_o[7:0]), 3);
        check("t1 hit0", 32'(hit_o[0]), 1);
        check("t1 no alarm yet", 32'(alarm_o), 0);
        cyc("t1 idle", 1, 0);
        check("t1 alarm", 32'(alarm_o), 1);
        check("t1 alarm_ch", 32'(alarm_ch_o), 0);

        // Saturation on a self-loop with zero threshold.
        clrc();
        cfgw(1, 1, 7, 7, 0, 0, 0);
        for (int i = 0; i < 262; i++) cyc("t2 hold7", 1, 7);
        check("t2 sat", 32'(cnt_o[15:8]), CMAX);
        check("t2 no hit1", 32'(hit_o[1]), 0);
        check("t2 no alarm", 32'(alarm_o), 0);

        // Windowed mode, window of 8 enabled cycles.
        clrc();
        cfgw(1, 0, 0, 0, 0, 0, 0);
        cfgw(2, 1, 1, 2, 2, 1, 8);
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("t3 w%0d", i), 1, seq3[i]);
            if (i == 3) begin
                check("t3 cnt2=2", 32'(cnt_o[23:16]), 2);
                check("t3 hit2", 32'(hit_o[2]), 1);
            end
        end
        check("t3 expiry cnt2", 32'(cnt_o[23:16]), 0);
        check("t3 expiry hit2", 32'(hit_o[2]), 0);
        check("t3 alarm kept", 32'(alarm_o), 1);
        check("t3 alarm_ch", 32'(alarm_ch_o), 2);

        // Simultaneous hits on ch1 and ch3.
        clrc();
        cfgw(2, 0, 0, 0, 0, 0, 0);
        cfgw(1, 1, 1, 2, 1, 0, 0);
        cfgw(3, 1, 1, 2, 1, 0, 0);
        cfgw(0, 1, 3, 4, 1, 0, 0);
        cyc("t4 s1", 1, 1);
        cyc("t4 s2", 1, 2);
        check("t4 hit13", 32'(hit_o), 32'b1010);
        cyc("t4 s0", 1, 0);
        check("t4 alarm_ch", 32'(alarm_ch_o), 1);
        cyc("t4 s3", 1, 3);
        cyc("t4 s4", 1, 4);
        cyc("t4 s0b", 1, 0);
        check("t4 alarm_ch held", 32'(alarm_ch_o), 1);

        // clr and cfg_we priority over a coincident match.
        clrc();
        cfgw(0, 1, 6, 1, 1, 0, 0);
        cyc("t5 s6", 1, 6);
        cyc("t5 s1", 1, 1);
        check("t5 pre cnt0", 32'(cnt_o[7:0]), 1);
        cyc("t5 s6b", 1, 6);
        drive("t5 clr+match", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t5 clr cnt0", 32'(cnt_o[7:0]), 0);
        check("t5 clr alarm", 32'(alarm_o), 0);
        cyc("t5 after clr", 1, 1);
        check("t5 no match pv0", 32'(cnt_o[7:0]), 0);
        cyc("t5 s6c", 1, 6);
        drive("t5 cfg+match", 1, 1, 0, 1, 0, 1, 1, 6, 1, 0, 0);
        check("t5 cfg cnt0", 32'(cnt_o[7:0]), 0);
        cyc("t5 new cfg", 1, 6);
        check("t5 new cfg cnt0", 32'(cnt_o[7:0]), 1);

        // en=0 gaps hold prev state; asynchronous reset mid-count.
        clrc();
        cfgw(0, 1, 6, 1, 5, 0, 0);
        cyc("t6 s6", 1, 6);
        cyc("t6 gap", 0, 3);
        cyc("t6 gap2", 0, 9);
        cyc("t6 s1", 1, 1);
        check("t6 gap count", 32'(cnt_o[7:0]), 1);
        cyc("t6 s6b", 1, 6);
        #2;
        rst = 1;
        model_reset();
        #1;
        check_all("t6 async rst");
        check("t6 rst cnt", 32'(cnt_o), 0);
        #2;
        rst = 0;

        // Randomized traffic against the model.
        for (int k = 0; k < NCH; k++)
            cfgw(k, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), 0, 0);
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive("rnd clr", $urandom_range(0, 1), $urandom_range(0, 3), 1, 0, 0, 0, 0, 0,
                      0, 0, 0);
            end else if (r < 7) begin
                drive("rnd cfg", $urandom_range(0, 1), $urandom_range(0, 3), 0, 1,
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1),
                      $urandom_range(0, 12));
            end else begin
                cyc("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
